// File: rtl/dcache_pkg.sv
// Shared types and widths for the data-cache controller slice.
// Tag field layout is {valid, dirty, tag[22:0]}.
package dcache_pkg;

    localparam int TAG_W       = 23;
    localparam int IDX_W       = 4;
    localparam int WORD_SEL_W  = 3;
    localparam int LINE_W      = 256;
    localparam int TAG_FIELD_W = 25;
    localparam int VALID_BIT   = 24;
    localparam int DIRTY_BIT   = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WRITEBACK,
        ST_READMEM,
        ST_FILL
    } state_e;

endpackage

// File: rtl/dcache_word_merge.sv
// Selects one 32-bit word from a cache line and builds the line with that
// word replaced by store data.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0]     line_i,
    input  logic [WORD_SEL_W-1:0] word_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    output logic [LINE_W-1:0]     line_o
);

    logic [7:0] bit_base;

    assign bit_base = {word_i, 5'b00000};
    assign rdata_o  = line_i[bit_base +: 32];

    always_comb begin
        line_o                = line_i;
        line_o[bit_base +: 32] = wdata_i;
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped-view cache controller: same-cycle hits, write-back of dirty
// victims, line refill from memory, then replay of the request as a hit.
//
// state      | meaning
// IDLE       | serve hits, detect misses
// MISS       | capture victim line/tag, pick write-back or refill
// WRITEBACK  | write dirty victim to memory, wait for ack
// READMEM    | fetch requested line, wait for ack
// FILL       | write fetched line into SRAM as clean
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cpu_req_i,
    input  logic                   cpu_write_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic [31:0]            cpu_data_i,
    output logic [31:0]            cpu_data_o,
    output logic                   cpu_stall_o,
    output logic [IDX_W-1:0]       sram_addr_o,
    output logic [TAG_FIELD_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]      sram_data_o,
    output logic                   sram_enable_o,
    output logic                   sram_write_o,
    input  logic [TAG_FIELD_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]      sram_data_i,
    input  logic                   sram_hit_i,
    output logic                   mem_enable_o,
    output logic                   mem_write_o,
    output logic [31:0]            mem_addr_o,
    output logic [LINE_W-1:0]      mem_data_o,
    input  logic [LINE_W-1:0]      mem_data_i,
    input  logic                   mem_ack_i
);

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   victim_line_q, victim_line_d;
    logic [TAG_W-1:0]    victim_tag_q, victim_tag_d;
    logic [LINE_W-1:0]   fill_line_q, fill_line_d;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WORD_SEL_W-1:0] req_word;
    logic [1:0]            addr_byte_unused;
    logic [31:0]           hit_rdata;
    logic [LINE_W-1:0]     hit_merged;

    assign req_tag          = cpu_addr_i[31:9];
    assign req_idx          = cpu_addr_i[8:5];
    assign req_word         = cpu_addr_i[4:2];
    assign addr_byte_unused = cpu_addr_i[1:0];

    dcache_word_merge u_word_merge (
        .line_i  (sram_data_i),
        .word_i  (req_word),
        .wdata_i (cpu_data_i),
        .rdata_o (hit_rdata),
        .line_o  (hit_merged)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            victim_line_q <= '0;
            victim_tag_q  <= '0;
            fill_line_q   <= '0;
        end else begin
            state_q       <= state_d;
            victim_line_q <= victim_line_d;
            victim_tag_q  <= victim_tag_d;
            fill_line_q   <= fill_line_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        victim_line_d = victim_line_q;
        victim_tag_d  = victim_tag_q;
        fill_line_d   = fill_line_q;
        cpu_data_o    = hit_rdata;
        cpu_stall_o   = 1'b0;
        sram_addr_o   = req_idx;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;

        // Outputs are forced quiet while reset is held, not just after it.
        if (!rst_i) begin
            cpu_stall_o = cpu_req_i && !((state_q == ST_IDLE) && sram_hit_i);
            unique case (state_q)
                ST_IDLE: begin
                    if (cpu_req_i) begin
                        if (sram_hit_i) begin
                            if (cpu_write_i) begin
                                sram_enable_o = 1'b1;
                                sram_write_o  = 1'b1;
                                sram_data_o   = hit_merged;
                                sram_tag_o    = {1'b1, 1'b1, req_tag};
                            end
                        end else begin
                            state_d = ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    victim_line_d = sram_data_i;
                    victim_tag_d  = sram_tag_i[TAG_W-1:0];
                    if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_READMEM;
                    end
                end
                ST_WRITEBACK: begin
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {victim_tag_q, req_idx, 5'b00000};
                    mem_data_o   = victim_line_q;
                    if (mem_ack_i) begin
                        state_d = ST_READMEM;
                    end
                end
                ST_READMEM: begin
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {req_tag, req_idx, 5'b00000};
                    if (mem_ack_i) begin
                        fill_line_d = mem_data_i;
                        state_d     = ST_FILL;
                    end
                end
                ST_FILL: begin
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_data_o   = fill_line_q;
                    sram_tag_o    = {1'b1, 1'b0, req_tag};
                    state_d       = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 16-set tag/data SRAM model.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i;

    logic [24:0]  tag_mem [16];
    logic [255:0] data_mem [16];
    logic         pre_en;
    logic [3:0]   pre_idx;
    logic [24:0]  pre_tag;
    logic [255:0] pre_data;
    int           sram_wr_cnt;

    int n_chk = 0;
    int n_bad = 0;

    logic [255:0] line_a, line_a_st, line_v, line_b, line_c;
    int stall_cnt, rm_cnt, guard, wr_before;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
        .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o),
        .sram_write_o(sram_write_o), .sram_tag_i(sram_tag_i),
        .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM model: one tag/line per set, hit when valid and tag matches.
    always_comb begin
        sram_tag_i  = tag_mem[cpu_addr_i[8:5]];
        sram_data_i = data_mem[cpu_addr_i[8:5]];
        sram_hit_i  = sram_tag_i[24] && (sram_tag_i[22:0] == cpu_addr_i[31:9]);
    end

    always @(posedge clk_i) begin
        if (pre_en) begin
            tag_mem[pre_idx]  <= pre_tag;
            data_mem[pre_idx] <= pre_data;
        end else if (sram_enable_o && sram_write_o) begin
            tag_mem[sram_addr_o]  <= sram_tag_o;
            data_mem[sram_addr_o] <= sram_data_o;
            sram_wr_cnt           <= sram_wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tag_mem[i]  = '0;
            data_mem[i] = '0;
        end
        sram_wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            line_a[i*32 +: 32] = 32'hA000_0000 + i;
            line_v[i*32 +: 32] = 32'h5A00_0000 + i;
            line_b[i*32 +: 32] = 32'hB000_0000 + i;
            line_c[i*32 +: 32] = 32'hC000_0000 + i;
        end
        line_a[0*32 +: 32] = 32'hDEADBEEF;
        line_a[4*32 +: 32] = 32'hDEADBEEF;
        line_a_st = line_a;
        line_a_st[1*32 +: 32] = 32'h12345678;

        pre_en = 0; pre_idx = '0; pre_tag = '0; pre_data = '0;
        cpu_req_i = 0; cpu_write_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
        mem_data_i = '0; mem_ack_i = 0;
        rst_i = 1;
        #1;
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_mem_en", mem_enable_o, 0);
        chk("rst_sram_en", sram_enable_o, 0);
        cyc(); cyc();
        rst_i = 0;
        cyc();

        // Idle with no request
        chk("idle_mem_en", mem_enable_o, 0);
        chk("idle_sram_wr", sram_write_o, 0);

        // Clean miss load to 0x120 (index 9, word 0)
        cpu_req_i = 1; cpu_addr_i = 32'h0000_0120; #1;
        chk("miss_stall", cpu_stall_o, 1);
        chk("sram_addr", sram_addr_o, 4'd9);
        cyc();
        chk("miss_mem_en", mem_enable_o, 0);
        cyc();
        chk("rd_en", mem_enable_o, 1);
        chk("rd_wr", mem_write_o, 0);
        chk("rd_addr", mem_addr_o, 32'h0000_0120);
        mem_ack_i = 1; mem_data_i = line_a;
        cyc();
        mem_ack_i = 0; #1;
        chk("fill_en", {sram_enable_o, sram_write_o}, 2'b11);
        chk("fill_tag", sram_tag_o, 25'h100_0000);
        chk("fill_data", sram_data_o, line_a);
        chk("fill_stall", cpu_stall_o, 1);
        cyc();
        chk("hit_stall", cpu_stall_o, 0);
        chk("hit_rdata", cpu_data_o, 32'hDEADBEEF);
        chk("load_no_wr", sram_enable_o, 0);

        // Further load hits on the same line
        cpu_addr_i = 32'h0000_0130; #1;
        chk("ld_w4", cpu_data_o, 32'hDEADBEEF);
        cpu_addr_i = 32'h0000_012C; #1;
        chk("ld_w3", cpu_data_o, 32'hA000_0003);
        chk("ld_w3_stall", cpu_stall_o, 0);

        // Store hit to 0x124 (word 1)
        cpu_write_i = 1; cpu_addr_i = 32'h0000_0124; cpu_data_i = 32'h1234_5678; #1;
        chk("st_stall", cpu_stall_o, 0);
        chk("st_en", {sram_enable_o, sram_write_o}, 2'b11);
        chk("st_tag", sram_tag_o, 25'h180_0000);
        chk("st_data", sram_data_o, line_a_st);
        cyc();
        cpu_req_i = 0; cpu_write_i = 0; #1;
        chk("st_commit", data_mem[9], line_a_st);

        // Dirty victim at index 9, load to 0x1120
        pre_en = 1; pre_idx = 4'd9; pre_tag = 25'h180_0001; pre_data = line_v;
        cyc();
        pre_en = 0;
        cpu_req_i = 1; cpu_addr_i = 32'h0000_1120; #1;
        chk("dm_stall", cpu_stall_o, 1);
        cyc();
        cyc();
        chk("wb_en", {mem_enable_o, mem_write_o}, 2'b11);
        chk("wb_addr", mem_addr_o, 32'h0000_0320);
        chk("wb_data", mem_data_o, line_v);
        cyc();
        chk("wb_hold", {mem_enable_o, mem_write_o}, 2'b11);
        mem_ack_i = 1;
        cyc();
        mem_ack_i = 0; #1;
        chk("wb_rd_wr", {mem_enable_o, mem_write_o}, 2'b10);
        chk("wb_rd_addr", mem_addr_o, 32'h0000_1120);
        mem_ack_i = 1; mem_data_i = line_b;
        cyc();
        mem_ack_i = 0; #1;
        chk("dm_fill_tag", sram_tag_o, 25'h100_0008);
        cyc();
        chk("dm_rdata", cpu_data_o, 32'hB000_0000);
        chk("dm_stall_end", cpu_stall_o, 0);
        cpu_req_i = 0;
        cyc();

        // Reset during READMEM, late ack ignored
        cpu_req_i = 1; cpu_addr_i = 32'h0000_2140; #1;
        cyc(); cyc();
        chk("rr_rd_en", mem_enable_o, 1);
        wr_before = sram_wr_cnt;
        rst_i = 1; cpu_req_i = 0; #1;
        chk("rr_mem_en", mem_enable_o, 0);
        chk("rr_stall", cpu_stall_o, 0);
        #2; rst_i = 0;
        cyc();
        mem_ack_i = 1; mem_data_i = line_c; #1;
        chk("rr_ack_mem_en", mem_enable_o, 0);
        cyc();
        mem_ack_i = 0;
        cyc();
        chk("rr_no_fill", sram_wr_cnt, wr_before);
        chk("rr_tag10", tag_mem[10], 25'h0);
        chk("rr_sram_en", sram_enable_o, 0);

        // Clean miss with 10-cycle read latency
        cpu_req_i = 1; cpu_addr_i = 32'h0000_2140; #1;
        stall_cnt = 0; rm_cnt = 0; guard = 0;
        while (cpu_stall_o && guard < 40) begin
            stall_cnt++;
            if (mem_enable_o) begin
                rm_cnt++;
                mem_ack_i = (rm_cnt == 10);
            end else begin
                mem_ack_i = 0;
            end
            cyc();
            guard++;
        end
        mem_ack_i = 0;
        chk("lat_timeout", guard < 40, 1);
        chk("lat_stall", stall_cnt, 13);
        chk("lat_rd_cycles", rm_cnt, 10);
        chk("lat_rdata", cpu_data_o, 32'hC000_0000);
        cpu_req_i = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
